sign_mag_to_twos: RTL and testbench
===================================

Name: sign_mag_to_twos

Overview:
- Converts a sign-magnitude result (sign flag plus unsigned magnitude) back to two's complement. It is the return path of the negation stage, used after magnitude-only multiply/accumulate in the 4x4 matrix multiplier datapath.
- Negative operands are negated bit-serially, LSB first, to save area: bits are copied up to and including the first 1, then every later bit is inverted.
- Out-of-range magnitudes are flagged and the output saturates.
- Uses valid/ready handshakes on both sides and holds one transaction at a time.

Parameters:
- Width, 8, data width in bits of the magnitude and the two's complement output; must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept an input.
- in_sign  in  1  1 = negative.
- in_mag  in  Width  unsigned magnitude.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  Width  signed two's complement result.
- out_ovf  out  1  magnitude was out of range; out_data is saturated.

Behaviour:
- Reset values (reset=1 at an edge): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_ovf=0, bit counter=0. Reset overrides everything, including an in-flight SHIFT or a pending DONE; the aborted transaction is dropped and never output.
- Accept: an input is taken at an edge where in_valid & in_ready. in_ready = (state==IDLE). in_ready does not depend combinationally on out_ready.
- Range rules (evaluated on the accepted values):
  - sign=0, mag ≤ 2^(W-1)-1: ovf=0.
  - sign=0, mag ≥ 2^(W-1): ovf=1, result 0111..1.
  - sign=1, mag ≤ 2^(W-1): ovf=0.
  - sign=1, mag > 2^(W-1): ovf=1, result 1000..0.
- IDLE, on accept:
  - sign=0, mag=0, or ovf=1: load the final result (mag, 0, or the saturated value) and go to DONE. Negative zero (sign=1, mag=0) yields 0 with ovf=0.
  - Otherwise (sign=1, 0 < mag ≤ 2^(W-1)): latch mag into a shift register, clear found_one, set counter=0, go to SHIFT.
- SHIFT, once per cycle for W cycles:
  - b = current LSB of the magnitude shift register.
  - Result bit = found_one ? ~b : b, shifted in at the MSB of the result register (right shift).
  - found_one <= found_one | b; counter increments.
  - When counter reaches W-1, the final bit is written and the state goes to DONE.
- DONE: out_valid=1. out_data and out_ovf are held stable until out_valid & out_ready at an edge. On that handshake go to IDLE, where out_valid=0 and in_ready=1. out_data keeps its last value after the handshake; it is don't-care while out_valid=0.
- Latency, counted from the accept edge to the edge at which out_valid is first sampled high:
  - Bypass paths (positive, zero, overflow): 1 cycle.
  - Serial negation: W+1 cycles.
- Throughput: at most one transaction per (latency + 1) cycles. There is no overlap: the next input is accepted no earlier than the edge after the output handshake.
- out_ready held high while in DONE: the handshake completes on the first DONE cycle.
- in_valid while not in IDLE is ignored. The source must hold its data until the handshake.
- Result width is exactly W bits. Magnitude 2^(W-1) with sign=1 produces 1000..0 with no overflow.

Test Plan (Width=8):
- sign=1, mag=5, out_ready=1 → out_valid rises 9 cycles after accept; out_data=0xFB, out_ovf=0; in_ready low throughout.
- sign=0, mag=127 → out_data=0x7F, ovf=0, latency 1. Then sign=0, mag=128 → out_data=0x7F, ovf=1.
- sign=1, mag=128 → 0x80, ovf=0, latency 9. Then sign=1, mag=200 → 0x80, ovf=1, latency 1. Then sign=1, mag=0 → 0x00, ovf=0, latency 1.
- Backpressure: sign=1, mag=1 with out_ready=0 for 4 cycles after out_valid → out_data=0xFF held stable, in_ready=0; handshake on the 5th cycle, then in_ready=1 the next cycle.
- Reset mid-SHIFT: accept sign=1, mag=3, assert reset at cycle 4 → next cycle out_valid=0, in_ready=1, out_data=0; no result emitted. A following input sign=1, mag=3 gives 0xFD.
- Randomised sweep of all 512 (sign, mag) pairs against a reference model; check latency per path and that out_data never changes while out_valid=1 & out_ready=0.

Source files
------------

// File: rtl/sign_mag_to_twos.sv
`default_nettype none
// ============================================================================
// Module   : sign_mag_to_twos
// Brief    : Sign-magnitude to two's complement converter with valid/ready
//            handshakes. Negative values are negated bit-serially, LSB first
//            (copy up to and including the first 1, invert afterwards).
//            Out-of-range magnitudes saturate and raise out_ovf.
// Revision : 1.0 - initial release
// ============================================================================
module sign_mag_to_twos #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [WIDTH-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]   c_max_pos  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_min_neg  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_shift,  w_shift_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_found,  w_found_nxt;
    logic [c_cnt_w-1:0] r_cnt,    w_cnt_nxt;
    logic               r_ovf,    w_ovf_nxt;

    logic w_accept;
    logic w_pos_ovf;
    logic w_neg_ovf;
    logic w_bit;
    logic w_res_bit;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_result;
    assign out_ovf   = r_ovf;

    assign w_accept  = in_valid & (r_state == IDLE);
    // +2^(W-1) and above cannot be represented; -2^(W-1) can.
    assign w_pos_ovf = ~in_sign & in_mag[WIDTH-1];
    assign w_neg_ovf = in_sign & (in_mag > c_min_neg);
    // Serial negation: once the first 1 has passed, every later bit flips.
    assign w_bit     = r_shift[0];
    assign w_res_bit = r_found ? ~w_bit : w_bit;

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_result <= w_result_nxt;
            r_found  <= w_found_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    // Next-state and datapath update: bypass loads, serial shift, handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_result_nxt = r_result;
        w_found_nxt  = r_found;
        w_cnt_nxt    = r_cnt;
        w_ovf_nxt    = r_ovf;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = '0;
                    w_found_nxt = 1'b0;
                    if (w_pos_ovf) begin
                        w_result_nxt = c_max_pos;
                        w_ovf_nxt    = 1'b1;
                        w_state_nxt  = DONE;
                    end else if (w_neg_ovf) begin
                        w_result_nxt = c_min_neg;
                        w_ovf_nxt    = 1'b1;
                        w_state_nxt  = DONE;
                    end else if (!in_sign) begin
                        w_result_nxt = in_mag;
                        w_ovf_nxt    = 1'b0;
                        w_state_nxt  = DONE;
                    end else if (in_mag == '0) begin
                        // Negative zero collapses to plain zero.
                        w_result_nxt = '0;
                        w_ovf_nxt    = 1'b0;
                        w_state_nxt  = DONE;
                    end else begin
                        w_shift_nxt = in_mag;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_result_nxt = {w_res_bit, r_result[WIDTH-1:1]};
                w_shift_nxt  = r_shift >> 1;
                w_found_nxt  = r_found | w_bit;
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sign_mag_to_twos.sv
`default_nettype none
// ============================================================================
// Module   : tb_sign_mag_to_twos
// Brief    : Self-checking bench for sign_mag_to_twos (WIDTH=8) using a
//            scoreboard queue filled at accept and drained at handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sign_mag_to_twos;

    localparam int c_w = 8;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic           in_sign;
    logic [c_w-1:0] in_mag;
    logic           out_valid;
    logic           out_ready;
    logic [c_w-1:0] out_data;
    logic           out_ovf;

    int n_checks;
    int n_fail;

    logic [c_w-1:0] q_data [$];
    logic           q_ovf  [$];
    int             q_lat  [$];

    sign_mag_to_twos #(.WIDTH(c_w)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic negation with explicit range limits.
    function automatic logic [c_w:0] ref_model(input logic s, input logic [c_w-1:0] m);
        logic [c_w-1:0] neg;
        neg = 8'd0 - m;
        if (!s) begin
            if (m > 8'd127) return {1'b1, 8'h7F};
            return {1'b0, m};
        end
        if (m > 8'd128) return {1'b1, 8'h80};
        return {1'b0, neg};
    endfunction

    function automatic int ref_lat(input logic s, input logic [c_w-1:0] m);
        return (s && m != 8'd0 && m <= 8'd128) ? c_w + 1 : 1;
    endfunction

    // One full transaction: present, accept, wait for result, stall, handshake.
    task automatic run_txn(input logic s, input logic [c_w-1:0] m, input int stall);
        logic [c_w:0]   exp;
        logic [c_w-1:0] e_data;
        logic           e_ovf;
        int             e_lat;
        int             w;
        int             lat;
        logic [c_w-1:0] held_d;
        logic           held_o;
        logic           busy_bad;

        @(negedge clk);
        in_valid  = 1'b1;
        in_sign   = s;
        in_mag    = m;
        out_ready = (stall == 0);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout s=%0b m=%0d in_ready=%b required 1", s, m, in_ready);
            in_valid = 1'b0;
            return;
        end
        exp = ref_model(s, m);
        q_data.push_back(exp[c_w-1:0]);
        q_ovf.push_back(exp[c_w]);
        q_lat.push_back(ref_lat(s, m));

        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_mag   = ~m;
        lat      = 1;
        busy_bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        e_data = q_data.pop_front();
        e_ovf  = q_ovf.pop_front();
        e_lat  = q_lat.pop_front();

        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL result_timeout s=%0b m=%0d out_valid=%b required 1", s, m, out_valid);
            return;
        end
        n_checks++;
        if (busy_bad || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_busy s=%0b m=%0d in_ready went high while busy, required 0", s, m);
        end
        n_checks++;
        if (lat !== e_lat) begin
            n_fail++;
            $display("FAIL latency s=%0b m=%0d got %0d required %0d", s, m, lat, e_lat);
        end

        held_d = out_data;
        held_o = out_ovf;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_ovf !== held_o || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold s=%0b m=%0d cyc=%0d valid=%b data=%h ovf=%b ready=%b required 1 %h %b 0",
                         s, m, i, out_valid, out_data, out_ovf, in_ready, held_d, held_o);
            end
        end
        out_ready = 1'b1;
        n_checks++;
        if (out_data !== e_data || out_ovf !== e_ovf) begin
            n_fail++;
            $display("FAIL result s=%0b m=%0d data=%h ovf=%b required data=%h ovf=%b",
                     s, m, out_data, out_ovf, e_data, e_ovf);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_handshake s=%0b m=%0d valid=%b in_ready=%b required 0 1",
                     s, m, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state in_ready=%b out_valid=%b out_data=%h out_ovf=%b required 1 0 00 0",
                     in_ready, out_valid, out_data, out_ovf);
        end
    endtask

    task automatic test_neg_basic();
        run_txn(1'b1, 8'd5, 0);
    endtask

    task automatic test_pos_bypass();
        run_txn(1'b0, 8'd127, 0);
        run_txn(1'b0, 8'd128, 0);
        run_txn(1'b0, 8'd0, 0);
    endtask

    task automatic test_neg_edges();
        run_txn(1'b1, 8'd128, 0);
        run_txn(1'b1, 8'd200, 0);
        run_txn(1'b1, 8'd0, 0);
        run_txn(1'b1, 8'd129, 0);
        run_txn(1'b1, 8'd255, 0);
    endtask

    task automatic test_backpressure();
        run_txn(1'b1, 8'd1, 4);
        run_txn(1'b0, 8'd42, 3);
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sign   = 1'b1;
        in_mag    = 8'd3;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_shift out_valid=%b in_ready=%b out_data=%h required 0 1 00",
                     out_valid, in_ready, out_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted_output out_valid seen=%b required 0", seen);
        end
        out_ready = 1'b0;
        run_txn(1'b1, 8'd3, 0);
    endtask

    task automatic test_sweep();
        logic [8:0] order [512];
        logic [8:0] tmp;
        int         j;
        for (int i = 0; i < 512; i++) order[i] = 9'(i);
        for (int i = 511; i > 0; i--) begin
            j        = $urandom_range(i, 0);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 512; i++) begin
            run_txn(order[i][8], order[i][7:0], $urandom_range(2, 0));
        end
    endtask

    // Test sequence.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_mag    = '0;
        out_ready = 1'b0;

        test_reset();
        test_neg_basic();
        test_pos_bypass();
        test_neg_edges();
        test_backpressure();
        test_reset_mid_shift();
        test_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
